// File: rtl/decode_pipe.sv
// -----------------------------------------------------------------------------
// decode_pipe
//
// Single-stage instruction decode with an 8-entry register file, write-back
// bypass, a busy-bit scoreboard for RAW hazards and a registered output with a
// valid/ready handshake. An instruction accepted in cycle N is presented on
// the out_* ports in cycle N+1 and held stable until it is taken or flushed.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   flush               kill the held output instruction (branch taken)
//   in_valid, in_ready  instruction input handshake
//   instr[15:0]         {opcode[3:0], imm_flag, rd[2:0], rs1[2:0], rs2[2:0]/imm[4:0]}
//   wb_en/wb_rd/wb_data register-file write-back port
//   out_valid/out_ready decoded-instruction handshake
//   out_opcode, out_imm_flag, out_rd, out_imm   decoded fields
//   out_op1, out_op2, out_branch_target        operands and branch target
//
// Parameters
//   DATA_W      operand / register / target width (16..64)
//   IMM_SIGNED  0: zero-extend imm, 1: sign-extend imm from bit 4
//   WR_MASK     bit k set means opcode k writes rd
// -----------------------------------------------------------------------------
module decode_pipe #(
   parameter int          DATA_W     = 16,
   parameter int          IMM_SIGNED = 0,
   parameter logic [15:0] WR_MASK    = 16'hFFFE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,

   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       instr,

   input  logic              wb_en,
   input  logic [2:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,

   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_opcode,
   output logic              out_imm_flag,
   output logic [2:0]        out_rd,
   output logic [4:0]        out_imm,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [DATA_W-1:0] out_branch_target
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] rf_q [8];
   logic [DATA_W-1:0] rf_d [8];
   logic [7:0]        busy_q,       busy_d;

   logic              out_valid_q,  out_valid_d;
   logic [3:0]        out_opcode_q, out_opcode_d;
   logic              out_imm_flag_q, out_imm_flag_d;
   logic [2:0]        out_rd_q,     out_rd_d;
   logic [4:0]        out_imm_q,    out_imm_d;
   logic [DATA_W-1:0] out_op1_q,    out_op1_d;
   logic [DATA_W-1:0] out_op2_q,    out_op2_d;
   logic [DATA_W-1:0] out_target_q, out_target_d;

   // ---------------------------------------------------------------------------
   // Field decode of the incoming instruction
   // ---------------------------------------------------------------------------
   logic [3:0] in_opcode;
   logic       in_imm_flag;
   logic [2:0] in_rd;
   logic [2:0] in_rs1;
   logic [2:0] in_rs2;
   logic [4:0] in_imm;

   assign in_opcode   = instr[15:12];
   assign in_imm_flag = instr[11];
   assign in_rd       = instr[10:8];
   assign in_rs1      = instr[7:5];
   assign in_rs2      = instr[4:2];
   assign in_imm      = instr[4:0];

   // ---------------------------------------------------------------------------
   // Operand read with write-back bypass, immediate extension, hazard detect
   // ---------------------------------------------------------------------------
   logic              wb_hit_rs1;
   logic              wb_hit_rs2;
   logic [DATA_W-1:0] rs1_val;
   logic [DATA_W-1:0] rs2_val;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] target_ext;
   logic              held_writes;
   logic              haz_rs1;
   logic              haz_rs2;
   logic              hazard;
   logic              xfer_in;
   logic              xfer_out;

   always_comb begin
      // NOTE: every signal written in an always_comb gets a value on every path
      // (here, unconditionally up front) so no latch can be inferred.
      wb_hit_rs1 = wb_en && (wb_rd == in_rs1);
      wb_hit_rs2 = wb_en && (wb_rd == in_rs2);

      rs1_val = wb_hit_rs1 ? wb_data : rf_q[in_rs1];
      rs2_val = wb_hit_rs2 ? wb_data : rf_q[in_rs2];

      if (IMM_SIGNED != 0) begin
         imm_ext = {{(DATA_W-5){in_imm[4]}}, in_imm};
      end else begin
         imm_ext = {{(DATA_W-5){1'b0}}, in_imm};
      end

      target_ext = {{(DATA_W-11){1'b0}}, instr[10:0]};

      // The held instruction has not set its busy bit yet (that happens on
      // transfer out), so its destination is compared separately. A write-back
      // arriving this cycle only cancels the scoreboard contribution: it
      // carries an older value, not the one the held instruction will produce.
      held_writes = out_valid_q && WR_MASK[out_opcode_q];

      haz_rs1 = (busy_q[in_rs1] && !wb_hit_rs1)
             || (held_writes && (out_rd_q == in_rs1));
      haz_rs2 = !in_imm_flag
             && ((busy_q[in_rs2] && !wb_hit_rs2)
              || (held_writes && (out_rd_q == in_rs2)));
      hazard  = haz_rs1 || haz_rs2;

      in_ready = (!out_valid_q || out_ready) && !hazard && !flush && !reset;
      xfer_in  = in_valid && in_ready;
      // A flush in the same cycle as out_ready wins: the instruction is killed,
      // not delivered.
      xfer_out = out_valid_q && out_ready && !flush;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      rf_d = rf_q;
      if (wb_en) begin
         rf_d[wb_rd] = wb_data;
      end

      // Clear first, then set, so a same-cycle set of the same bit wins.
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_rd] = 1'b0;
      end
      if (xfer_out && WR_MASK[out_opcode_q]) begin
         busy_d[out_rd_q] = 1'b1;
      end

      out_valid_d    = out_valid_q;
      out_opcode_d   = out_opcode_q;
      out_imm_flag_d = out_imm_flag_q;
      out_rd_d       = out_rd_q;
      out_imm_d      = out_imm_q;
      out_op1_d      = out_op1_q;
      out_op2_d      = out_op2_q;
      out_target_d   = out_target_q;

      if (xfer_in) begin
         // in_ready already excludes flush, so loading never races a kill.
         out_valid_d    = 1'b1;
         out_opcode_d   = in_opcode;
         out_imm_flag_d = in_imm_flag;
         out_rd_d       = in_rd;
         out_imm_d      = in_imm;
         out_op1_d      = rs1_val;
         out_op2_d      = in_imm_flag ? imm_ext : rs2_val;
         out_target_d   = target_ext;
      end else if (flush || xfer_out) begin
         out_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         // NOTE: the register file is built from flops and must read as zero
         // after reset, so it is cleared here like any other state; a RAM
         // macro could not be reset this way.
         for (int i = 0; i < 8; i++) begin
            rf_q[i] <= '0;
         end
         busy_q         <= '0;
         out_valid_q    <= 1'b0;
         out_opcode_q   <= '0;
         out_imm_flag_q <= 1'b0;
         out_rd_q       <= '0;
         out_imm_q      <= '0;
         out_op1_q      <= '0;
         out_op2_q      <= '0;
         out_target_q   <= '0;
      end else begin
         rf_q           <= rf_d;
         busy_q         <= busy_d;
         out_valid_q    <= out_valid_d;
         out_opcode_q   <= out_opcode_d;
         out_imm_flag_q <= out_imm_flag_d;
         out_rd_q       <= out_rd_d;
         out_imm_q      <= out_imm_d;
         out_op1_q      <= out_op1_d;
         out_op2_q      <= out_op2_d;
         out_target_q   <= out_target_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign out_valid         = out_valid_q;
   assign out_opcode        = out_opcode_q;
   assign out_imm_flag      = out_imm_flag_q;
   assign out_rd            = out_rd_q;
   assign out_imm           = out_imm_q;
   assign out_op1           = out_op1_q;
   assign out_op2           = out_op2_q;
   assign out_branch_target = out_target_q;

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter DATA_W, default 16: operand, register and branch-target width; legal values 16..64.
REQ-002 Parameter IMM_SIGNED, default 0: 0 zero-extends imm, 1 sign-extends imm (bit 4) to DATA_W.
REQ-003 Parameter WR_MASK, 16 bits, default 16'hFFFE: bit k=1 means opcode k writes rd.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 flush  in  1  branch-taken kill of the held output instruction.
REQ-007 in_valid / in_ready  in / out  1 / 1  instruction handshake.
REQ-008 instr  in  16  [15:12] opcode, [11] imm_flag, [10:8] rd, [7:5] rs1, [4:2] rs2, [4:0] imm.
REQ-009 wb_en, wb_rd, wb_data  in  1, 3, DATA_W  register-file write-back port.
REQ-010 out_valid / out_ready  out / in  1 / 1  decoded-instruction handshake.
REQ-011 out_opcode, out_imm_flag, out_rd, out_imm  out  4, 1, 3, 5  decoded fields.
REQ-012 out_op1, out_op2, out_branch_target  out  DATA_W each  operands and target.

Function
REQ-013 Register file: 8 x DATA_W; written only via wb port; no hardwired-zero register.
REQ-014 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-015 Latency: instruction accepted in cycle N appears on outputs with out_valid=1 in cycle N+1.
REQ-016 Output register holds all out_* stable while out_valid && !out_ready.
REQ-017 op1 = RF[rs1]; op2 = imm extended per IMM_SIGNED when imm_flag=1, else RF[rs2].
REQ-018 branch_target = instr[10:0] zero-extended to DATA_W.
REQ-019 Bypass: if wb_en and wb_rd equals a source read in the accept cycle, wb_data is used.
REQ-020 Scoreboard busy[7:0]: bit rd set on transfer out when WR_MASK[opcode]=1; bit wb_rd cleared when wb_en.
REQ-021 Same-cycle set and clear of one bit: set wins.
REQ-022 Hazard = rs1 busy, or rs2 busy with imm_flag=0, or either matches held out_rd (out_valid, writing opcode); a bypassed wb to that register cancels the busy contribution only.
REQ-023 in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-024 Flush: out_valid cleared next cycle, held instruction discarded, no busy bit set for it, no input accepted that cycle; busy bits of already-issued instructions unchanged.
REQ-025 Flush with out_ready=1 in same cycle: flush wins, no transfer out.
REQ-026 Back-to-back: with no hazard and out_ready=1, one instruction per cycle sustained.

Reset
REQ-027 Reset: out_valid=0, all out_* fields 0, busy=0, all 8 registers 0, in_ready=0 during reset.
REQ-028 Reset mid-operation discards held instruction and any wb in that cycle; reset dominates flush.

Verification
REQ-029 Reset, wb r2=0x1234, instr 0x1047 (op1, imm_flag=0, rd0, rs1=r2, rs2=r1) -> next cycle out_op1=0x1234, out_op2=0, out_valid=1.
REQ-030 instr imm form 0x185F (imm=31), IMM_SIGNED=1 -> out_op2=0xFFFF; IMM_SIGNED=0 -> 0x001F.
REQ-031 Issue writer to r3, next instr reads r3 -> in_ready=0 until wb_en r3; wb cycle accepts with op1=wb_data.
REQ-032 out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0; release -> one transfer.
REQ-033 flush while output held -> out_valid=0 next cycle, busy unchanged, next accepted instruction decodes normally.
REQ-034 wb_en r5 same cycle as transfer out of writer to r5 -> busy[5]=1 afterwards.
